// File: rtl/axis_loop_fifo.sv
// axis_loop_fifo
//   Buffered AXI-Stream loopback. A DEPTH-entry first-word-fall-through FIFO
//   sits between the slave (input) and master (output) stream interfaces.
//   Upstream can keep bursting while downstream stalls. The module also
//   reports the current fill level.
//
//   Parameters
//     WIDTH : tdata width in bits (>= 1)
//     DEPTH : number of FIFO entries (power of two, >= 2)
//
//   Ports
//     clk, rst        : single rising-edge clock, synchronous active-high reset
//     s_axis_*        : input beat stream (tdata, tvalid, tready)
//     m_axis_*        : output beat stream (tdata = FIFO head, tvalid = non-empty)
//     flush           : synchronous clear of contents, pointers and counters
//     level           : current occupancy, 0..DEPTH
//
//   Optional statistics (define AXIS_LOOP_FIFO_STATS_EN)
//     in_count        : pushes since rst/flush, wraps
//     out_count       : pops since rst/flush, wraps
//     stall_cyc       : cycles with output valid but not ready, saturates
module axis_loop_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [WIDTH-1:0]             m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef AXIS_LOOP_FIFO_STATS_EN
  ,
  output logic [31:0]                  in_count,
  output logic [31:0]                  out_count,
  output logic [31:0]                  stall_cyc
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH + 1);

  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;

  // Ready depends only on registered occupancy, so there is no
  // combinational path from m_axis_tready back to s_axis_tready.
  assign s_axis_tready = (level != LVL_FULL);
  assign m_axis_tvalid = (level != '0);
  assign m_axis_tdata  = mem[rd_ptr];

  // A flush swallows any coincident beat on either side.
  assign push = s_axis_tvalid & s_axis_tready & ~flush;
  assign pop  = m_axis_tvalid & m_axis_tready & ~flush;

  // Storage is data only; its contents are irrelevant while level == 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

`ifdef AXIS_LOOP_FIFO_STATS_EN
  logic stall;
  assign stall = m_axis_tvalid & ~m_axis_tready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      in_count  <= '0;
      out_count <= '0;
      stall_cyc <= '0;
    end else begin
      if (push) in_count  <= in_count + 32'd1;
      if (pop)  out_count <= out_count + 32'd1;
      if (stall && (stall_cyc != 32'hFFFF_FFFF)) stall_cyc <= stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_loop_fifo.sv
// Testbench for axis_loop_fifo: a WIDTH=8/DEPTH=4 instance exercised by
// directed sequences, plus a WIDTH=32/DEPTH=16 instance for the deep-fill
// case. Accepted input beats are queued as expectations; negedge monitors
// pop and compare whenever an output beat is taken.
module tb_axis_loop_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [2:0]  level;

  logic [31:0] s_data2 = '0;
  logic        s_valid2 = 1'b0;
  logic        s_ready2;
  logic [31:0] m_data2;
  logic        m_valid2;
  logic        m_ready2 = 1'b0;
  logic        flush2 = 1'b0;
  logic [4:0]  level2;

`ifdef AXIS_LOOP_FIFO_STATS_EN
  logic [31:0] in_count, out_count, stall_cyc;
  logic [31:0] in_count2, out_count2, stall_cyc2;
`endif

  axis_loop_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .flush(flush), .level(level)
`ifdef AXIS_LOOP_FIFO_STATS_EN
    , .in_count(in_count), .out_count(out_count), .stall_cyc(stall_cyc)
`endif
  );

  axis_loop_fifo #(.WIDTH(32), .DEPTH(16)) dut2 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data2), .s_axis_tvalid(s_valid2), .s_axis_tready(s_ready2),
    .m_axis_tdata(m_data2), .m_axis_tvalid(m_valid2), .m_axis_tready(m_ready2),
    .flush(flush2), .level(level2)
`ifdef AXIS_LOOP_FIFO_STATS_EN
    , .in_count(in_count2), .out_count(out_count2), .stall_cyc(stall_cyc2)
`endif
  );

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  int pops2  = 0;
  logic [7:0]  q  [$];
  logic [31:0] q2 [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, 8-bit instance
  always @(negedge clk) begin
    if (rst || flush) begin
      q.delete();
    end else begin
      if (m_valid && m_ready) begin
        pops++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got 0x%0h expected no beat", m_data);
        end else begin
          chk("sb_data", 32'(m_data), 32'(q.pop_front()));
        end
      end
      if (s_valid && s_ready) q.push_back(s_data);
    end
  end

  // Scoreboard monitor, 32-bit instance
  always @(negedge clk) begin
    if (rst || flush2) begin
      q2.delete();
    end else begin
      if (m_valid2 && m_ready2) begin
        pops2++;
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb2_unexpected: got 0x%0h expected no beat", m_data2);
        end else begin
          chk("sb2_data", m_data2, q2.pop_front());
        end
      end
      if (s_valid2 && s_ready2) q2.push_back(s_data2);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int idx;
    int p0;
    int bad;
    logic acc;

    // Reset state
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst2_level", 32'(level2), 32'd0);

    // Single beat, one-cycle fall-through
    s_valid = 1'b1; s_data = 8'hA5;
    cyc();
    s_valid = 1'b0;
    chk("t1_level", 32'(level), 32'd1);
    chk("t1_m_valid", 32'(m_valid), 32'd1);
    chk("t1_m_data", 32'(m_data), 32'hA5);
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    chk("t1_empty", 32'(m_valid), 32'd0);

    // Burst 1..6 into a stalled output, then release
    p0 = pops;
    idx = 1;
    for (int c = 0; c < 20; c++) begin
      if (c == 8) m_ready = 1'b1;
      s_valid = (idx <= 6);
      s_data  = 8'(idx);
      acc = s_valid && s_ready;
      cyc();
      if (acc) idx++;
      if (c == 6) begin
        chk("t2_level_full", 32'(level), 32'd4);
        chk("t2_s_ready_low", 32'(s_ready), 32'd0);
        chk("t2_accepted", 32'(idx - 1), 32'd4);
      end
    end
    s_valid = 1'b0; m_ready = 1'b0;
    chk("t2_pops", 32'(pops - p0), 32'd6);
    chk("t2_level_end", 32'(level), 32'd0);

    // Continuous streaming with random data at constant level 2
    p0 = pops;
    s_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_data = 8'($urandom);
      cyc();
    end
    m_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 998; i++) begin
      s_data = 8'($urandom);
      cyc();
      if (level !== 3'd2) bad++;
    end
    s_valid = 1'b0;
    cyc(); cyc(); cyc();
    m_ready = 1'b0;
    chk("t3_level_const", 32'(bad), 32'd0);
    chk("t3_pops", 32'(pops - p0), 32'd1000);

    // FULL with push and pop offered together: pop only
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 8'h40 + 8'(i);
      cyc();
    end
    chk("t4_full", 32'(level), 32'd4);
    s_data = 8'h99; m_ready = 1'b1;
    cyc();
    s_valid = 1'b0; m_ready = 1'b0;
    chk("t4_level", 32'(level), 32'd3);
    chk("t4_s_ready", 32'(s_ready), 32'd1);
    m_ready = 1'b1;
    cyc(); cyc(); cyc();
    m_ready = 1'b0;
    chk("t4_drained", 32'(level), 32'd0);

    // Flush with a coincident push
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 8'h31 + 8'(i);
      cyc();
    end
    chk("t5_level3", 32'(level), 32'd3);
    flush = 1'b1; s_data = 8'h77;
    cyc();
    flush = 1'b0; s_valid = 1'b0;
    chk("t5_flush_level", 32'(level), 32'd0);
    chk("t5_flush_valid", 32'(m_valid), 32'd0);
    s_valid = 1'b1; s_data = 8'h11;
    cyc();
    s_valid = 1'b0;
    chk("t5_after_flush", 32'(m_data), 32'h11);
    // Reset mid-burst
    s_valid = 1'b1; s_data = 8'h21;
    cyc();
    s_data = 8'h22;
    cyc();
    rst = 1'b1; s_data = 8'h23;
    cyc();
    rst = 1'b0; s_valid = 1'b0;
    chk("t5_rst_level", 32'(level), 32'd0);
    chk("t5_rst_valid", 32'(m_valid), 32'd0);
    chk("t5_rst_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1; s_data = 8'h55;
    cyc();
    s_valid = 1'b0; m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    chk("t5_post_rst", 32'(level), 32'd0);

`ifdef AXIS_LOOP_FIFO_STATS_EN
    // 10 pushes, 7 pops, 5 stall cycles
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      s_data = 8'hC0 + 8'(i);
      cyc();
    end
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_data = 8'hD0 + 8'(i);
      cyc();
    end
    s_valid = 1'b0;
    cyc(); cyc();
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    chk("st_in_count", in_count, 32'd10);
    chk("st_out_count", out_count, 32'd7);
    chk("st_stall_cyc", stall_cyc, 32'd5);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("st_flush_in", in_count, 32'd0);
    chk("st_flush_stall", stall_cyc, 32'd0);
`endif

    // Deep instance: 20 beats into a stalled 16-entry FIFO
    p0 = pops2;
    idx = 1;
    for (int c = 0; c < 50; c++) begin
      if (c == 24) m_ready2 = 1'b1;
      s_valid2 = (idx <= 20);
      s_data2  = 32'hA000_0000 + 32'(idx);
      acc = s_valid2 && s_ready2;
      cyc();
      if (acc) idx++;
      if (c == 22) begin
        chk("d_level_full", 32'(level2), 32'd16);
        chk("d_s_ready_low", 32'(s_ready2), 32'd0);
        chk("d_accepted", 32'(idx - 1), 32'd16);
      end
    end
    s_valid2 = 1'b0; m_ready2 = 1'b0;
    chk("d_pops", 32'(pops2 - p0), 32'd20);
    chk("d_level_end", 32'(level2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
